// File: rtl/sisc_fetch.sv
// Instruction fetch stage for SISC: owns the PC, runs the req/ack fetch port
// and holds the fetched word in ir until the consumer takes it.
module sisc_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redir;
  logic              squash;

  // Fetch port: imem_req stays high with imem_addr stable from the first FETCH
  // cycle until the edge that samples the one-cycle imem_ack pulse; acks seen
  // outside FETCH are ignored.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      pc_out   <= '0;
      squash   <= 1'b0;
      redir    <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            squash <= 1'b0;
            // A redirect arriving with the ack overrides any pending redir.
            if (br_taken) begin
              pc <= br_target;
            end else if (squash) begin
              pc <= redir;
            end else begin
              ir       <= imem_rdata;
              pc_out   <= pc;
              pc       <= pc + 1'b1;
              ir_valid <= 1'b1;
              state    <= ISSUE;
            end
          end else if (br_taken) begin
            // The outstanding request cannot be withdrawn; remember to drop it.
            squash <= 1'b1;
            redir  <= br_target;
          end
        end
        ISSUE: begin
          if (br_taken) begin
            ir_valid <= 1'b0;
            pc       <= br_target;
            state    <= FETCH;
          end else if (!stall) begin
            ir_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
